// File: rtl/cpu_pkg.sv
// Shared definitions for the nibble processor decoder: opcode classes,
// register indices, bus source codes and the control bundle layout.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_LOAD,
    OP_MOV,
    OP_ALU,
    OP_JMP,
    OP_JNZ
  } opcode_e;

  typedef enum logic [3:0] {
    REG_X0   = 4'd0,
    REG_X1   = 4'd1,
    REG_Y0   = 4'd2,
    REG_Y1   = 4'd3,
    REG_R    = 4'd4,
    REG_M    = 4'd5,
    REG_I    = 4'd6,
    REG_DM   = 4'd7,
    REG_OREG = 4'd8
  } reg_idx_e;

  localparam logic [3:0] SRC_IMM  = 4'd8;
  localparam logic [3:0] SRC_NONE = 4'd10;

  // ALU encodings whose result is discarded; they retire as NOPs.
  localparam int unsigned          NUM_NOPS = 4;
  localparam logic [NUM_NOPS*8-1:0] NOP_OPS  = {8'hDF, 8'hD8, 8'hCF, 8'hC8};

  typedef struct packed {
    logic [8:0] reg_en;
    logic [3:0] source_sel;
    logic       i_sel;
    logic       x_sel;
    logic       y_sel;
    logic       jmp;
    logic       jmp_nz;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{reg_en: 9'h000, source_sel: SRC_NONE, i_sel: 1'b0,
                                    x_sel: 1'b0, y_sel: 1'b0, jmp: 1'b0, jmp_nz: 1'b0};
  localparam ctrl_t CTRL_RESET  = '{reg_en: 9'h1FF, source_sel: SRC_NONE, i_sel: 1'b0,
                                    x_sel: 1'b0, y_sel: 1'b0, jmp: 1'b0, jmp_nz: 1'b0};

  function automatic opcode_e op_class(input logic [3:0] op_bits);
    if (!op_bits[3]) return OP_LOAD;
    if (!op_bits[2]) return OP_MOV;
    if (!op_bits[1]) return OP_ALU;
    if (!op_bits[0]) return OP_JMP;
    return OP_JNZ;
  endfunction

  function automatic logic is_nop_byte(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < NUM_NOPS; k++) begin
      if (b == NOP_OPS[k*8 +: 8]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Pure combinational decode of one instruction word into the control bundle,
// immediate field and NOP flag.
module instr_decode_comb
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned SRC_MODE = 0
) (
  input  logic [DATA_W+3:0] instr_i,
  input  logic [3:0]        o_reg_i,
  output ctrl_t             ctrl_o,
  output logic [DATA_W-1:0] imm_o,
  output logic              nop_o
);

  localparam int unsigned INSTR_W = DATA_W + 4;

  logic [3:0] op_bits;
  logic [2:0] dst;
  logic [2:0] src;
  logic       unused_o_reg;

  assign op_bits      = instr_i[INSTR_W-1 -: 4];
  assign dst          = instr_i[5:3];
  assign src          = (SRC_MODE == 1) ? o_reg_i[2:0] : instr_i[2:0];
  assign unused_o_reg = ^o_reg_i;

  always_comb begin
    ctrl_o            = CTRL_BUBBLE;
    ctrl_o.source_sel = {1'b0, src};
    imm_o             = instr_i[DATA_W-1:0];
    nop_o             = (op_bits[3:1] == 3'b110) && is_nop_byte(instr_i[7:0]);
    case (op_class(op_bits))
      OP_LOAD: begin
        ctrl_o.reg_en     = 9'(1) << op_bits[2:0];
        ctrl_o.source_sel = SRC_IMM;
      end
      OP_MOV: begin
        // r->r is meaningless, so that encoding is reused for mov r->o_reg
        if (({1'b0, dst} == REG_R) && ({1'b0, instr_i[2:0]} == REG_R)) begin
          ctrl_o.reg_en     = 9'(1) << REG_OREG;
          ctrl_o.source_sel = REG_R;
        end else begin
          ctrl_o.reg_en = 9'(1) << dst;
        end
      end
      OP_ALU: begin
        ctrl_o.x_sel = op_bits[0];
        ctrl_o.y_sel = instr_i[INSTR_W-5];
        if (!nop_o) ctrl_o.reg_en = 9'(1) << REG_R;
      end
      OP_JMP: begin
        ctrl_o.jmp   = 1'b1;
        ctrl_o.i_sel = 1'b1;
      end
      OP_JNZ: begin
        ctrl_o.jmp_nz = 1'b1;
        ctrl_o.i_sel  = 1'b1;
      end
      default: ctrl_o = CTRL_BUBBLE;
    endcase
  end

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Two-stage (IR -> CTRL) registered instruction decoder with fetch handshake,
// datapath hold, wrong-path squashing on taken jumps and a saturating NOP counter.
module pipelined_instruction_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned SRC_MODE = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              sync_reset_n,
  input  logic [DATA_W+3:0] next_instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              hold,
  input  logic              zero_flag,
  input  logic [3:0]        o_reg,
  output logic              jmp,
  output logic              jmp_nz,
  output logic              flush,
  output logic              i_sel,
  output logic              x_sel,
  output logic              y_sel,
  output logic [3:0]        source_sel,
  output logic [DATA_W-1:0] ir_nibble,
  output logic [8:0]        reg_en,
  output logic [CNT_W-1:0]  nop_count
);

  localparam int unsigned INSTR_W = DATA_W + 4;

  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_v_q, ir_v_d;
  ctrl_t              ctrl_q, ctrl_d, dec_ctrl;
  logic [DATA_W-1:0]  imm_q, imm_d, dec_imm;
  logic [CNT_W-1:0]   nop_q, nop_d;
  logic               dec_nop;
  logic               taken;
  logic               advance;

  instr_decode_comb #(
    .DATA_W  (DATA_W),
    .SRC_MODE(SRC_MODE)
  ) u_decode (
    .instr_i(ir_q),
    .o_reg_i(o_reg),
    .ctrl_o (dec_ctrl),
    .imm_o  (dec_imm),
    .nop_o  (dec_nop)
  );

  assign taken       = ctrl_q.jmp | (ctrl_q.jmp_nz & ~zero_flag);
  assign flush       = taken & ~hold;
  assign instr_ready = ~hold;
  // A flushed IR entry is wrong-path and must never reach CTRL.
  assign advance     = ir_v_q & ~flush;

  always_comb begin
    ir_d   = ir_q;
    ir_v_d = ir_v_q;
    ctrl_d = ctrl_q;
    imm_d  = imm_q;
    nop_d  = nop_q;
    if (!hold) begin
      if (flush) begin
        ir_v_d = 1'b0;
      end else if (instr_valid) begin
        ir_d   = next_instr;
        ir_v_d = 1'b1;
      end else begin
        ir_v_d = 1'b0;
      end
      if (advance) begin
        ctrl_d = dec_ctrl;
        imm_d  = dec_imm;
        if (dec_nop && (nop_q != '1)) nop_d = nop_q + 1'b1;
      end else begin
        ctrl_d = CTRL_BUBBLE;
        imm_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      ir_q   <= '0;
      ir_v_q <= 1'b0;
      ctrl_q <= CTRL_RESET;
      imm_q  <= '0;
      nop_q  <= '0;
    end else begin
      ir_q   <= ir_d;
      ir_v_q <= ir_v_d;
      ctrl_q <= ctrl_d;
      imm_q  <= imm_d;
      nop_q  <= nop_d;
    end
  end

  assign jmp        = ctrl_q.jmp;
  assign jmp_nz     = ctrl_q.jmp_nz;
  assign i_sel      = ctrl_q.i_sel;
  assign x_sel      = ctrl_q.x_sel;
  assign y_sel      = ctrl_q.y_sel;
  assign source_sel = ctrl_q.source_sel;
  assign reg_en     = ctrl_q.reg_en;
  assign ir_nibble  = imm_q;
  assign nop_count  = nop_q;

endmodule

// File: tb/tb_pipelined_instruction_decoder.sv
// Directed bench for pipelined_instruction_decoder: instance A uses SRC_MODE=0,
// instance B uses SRC_MODE=1; both see identical stimulus.
module tb_pipelined_instruction_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] next_instr;
  logic       instr_valid;
  logic       hold;
  logic       zero_flag;
  logic [3:0] o_reg;

  logic       ready_a, jmp_a, jnz_a, flush_a, isel_a, xsel_a, ysel_a;
  logic [3:0] src_a, imm_a;
  logic [8:0] en_a;
  logic [7:0] nop_a;
  logic       ready_b, jmp_b, jnz_b, flush_b, isel_b, xsel_b, ysel_b;
  logic [3:0] src_b, imm_b;
  logic [8:0] en_b;
  logic [7:0] nop_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_instruction_decoder #(.DATA_W(4), .SRC_MODE(0), .CNT_W(8)) dut_a (
    .clk(clk), .sync_reset_n(rst_n), .next_instr(next_instr), .instr_valid(instr_valid),
    .instr_ready(ready_a), .hold(hold), .zero_flag(zero_flag), .o_reg(o_reg),
    .jmp(jmp_a), .jmp_nz(jnz_a), .flush(flush_a), .i_sel(isel_a), .x_sel(xsel_a),
    .y_sel(ysel_a), .source_sel(src_a), .ir_nibble(imm_a), .reg_en(en_a), .nop_count(nop_a)
  );

  pipelined_instruction_decoder #(.DATA_W(4), .SRC_MODE(1), .CNT_W(8)) dut_b (
    .clk(clk), .sync_reset_n(rst_n), .next_instr(next_instr), .instr_valid(instr_valid),
    .instr_ready(ready_b), .hold(hold), .zero_flag(zero_flag), .o_reg(o_reg),
    .jmp(jmp_b), .jmp_nz(jnz_b), .flush(flush_b), .i_sel(isel_b), .x_sel(xsel_b),
    .y_sel(ysel_b), .source_sel(src_b), .ir_nibble(imm_b), .reg_en(en_b), .nop_count(nop_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [7:0] w);
    next_instr  = w;
    instr_valid = 1'b1;
    step();
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; hold = 1'b0;
    step(); step();
    n_checks++; if (en_a !== 9'h1FF) begin n_fail++; $display("FAIL rst_en got=%h exp=%h", en_a, 9'h1FF); end
    n_checks++; if (src_a !== 4'd10) begin n_fail++; $display("FAIL rst_src got=%0d exp=10", src_a); end
    n_checks++; if (jmp_a !== 1'b0 || jnz_a !== 1'b0) begin n_fail++; $display("FAIL rst_jmp got=%b%b exp=00", jmp_a, jnz_a); end
    rst_n = 1'b1;
    step();
    n_checks++; if (en_a !== 9'h000) begin n_fail++; $display("FAIL post_rst_en got=%h exp=000", en_a); end
    n_checks++; if (src_a !== 4'd10) begin n_fail++; $display("FAIL post_rst_src got=%0d exp=10", src_a); end
    n_checks++; if (nop_a !== 8'd0) begin n_fail++; $display("FAIL post_rst_nop got=%0d exp=0", nop_a); end
    n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got=%b exp=1", ready_a); end
  endtask

  task automatic test_stream();
    fetch(8'h05);
    fetch(8'h8A);
    n_checks++; if (en_a !== 9'h001) begin n_fail++; $display("FAIL load_en got=%h exp=001", en_a); end
    n_checks++; if (src_a !== 4'd8) begin n_fail++; $display("FAIL load_src got=%0d exp=8", src_a); end
    n_checks++; if (imm_a !== 4'h5) begin n_fail++; $display("FAIL load_imm got=%h exp=5", imm_a); end
    fetch(8'hC3);
    n_checks++; if (en_a !== 9'h002) begin n_fail++; $display("FAIL mov_en got=%h exp=002", en_a); end
    n_checks++; if (src_a !== 4'd2) begin n_fail++; $display("FAIL mov_src got=%0d exp=2", src_a); end
    fetch(8'hDB);
    n_checks++; if (en_a !== 9'h010) begin n_fail++; $display("FAIL alu_en got=%h exp=010", en_a); end
    n_checks++; if (xsel_a !== 1'b0 || ysel_a !== 1'b0) begin n_fail++; $display("FAIL alu_xy got=%b%b exp=00", xsel_a, ysel_a); end
    n_checks++; if (src_a !== 4'd3) begin n_fail++; $display("FAIL alu_src got=%0d exp=3", src_a); end
    idle();
    n_checks++; if (xsel_a !== 1'b1 || ysel_a !== 1'b1) begin n_fail++; $display("FAIL alu_xy11 got=%b%b exp=11", xsel_a, ysel_a); end
    n_checks++; if (en_a !== 9'h010) begin n_fail++; $display("FAIL alu2_en got=%h exp=010", en_a); end
    idle();
    n_checks++; if (en_a !== 9'h000 || src_a !== 4'd10) begin n_fail++; $display("FAIL bubble got en=%h src=%0d exp en=000 src=10", en_a, src_a); end
  endtask

  task automatic test_jump();
    fetch(8'hE7);
    fetch(8'h10);
    next_instr = 8'h20; instr_valid = 1'b1;
    #1;
    n_checks++; if (jmp_a !== 1'b1) begin n_fail++; $display("FAIL jmp got=%b exp=1", jmp_a); end
    n_checks++; if (flush_a !== 1'b1) begin n_fail++; $display("FAIL jmp_flush got=%b exp=1", flush_a); end
    n_checks++; if (isel_a !== 1'b1 || imm_a !== 4'h7) begin n_fail++; $display("FAIL jmp_target got isel=%b imm=%h exp isel=1 imm=7", isel_a, imm_a); end
    step();
    n_checks++; if (flush_a !== 1'b0 || jmp_a !== 1'b0) begin n_fail++; $display("FAIL after_jmp got flush=%b jmp=%b exp 0 0", flush_a, jmp_a); end
    n_checks++; if (en_a !== 9'h000) begin n_fail++; $display("FAIL squash1_en got=%h exp=000", en_a); end
    fetch(8'h03);
    n_checks++; if (en_a !== 9'h000) begin n_fail++; $display("FAIL squash2_en got=%h exp=000", en_a); end
    idle();
    n_checks++; if (en_a !== 9'h001 || imm_a !== 4'h3) begin n_fail++; $display("FAIL target_decode got en=%h imm=%h exp en=001 imm=3", en_a, imm_a); end
    idle();
  endtask

  task automatic test_jnz();
    zero_flag = 1'b1;
    fetch(8'hF3);
    fetch(8'h05);
    next_instr = 8'h8A; instr_valid = 1'b1;
    #1;
    n_checks++; if (jnz_a !== 1'b1) begin n_fail++; $display("FAIL jnz got=%b exp=1", jnz_a); end
    n_checks++; if (flush_a !== 1'b0) begin n_fail++; $display("FAIL jnz_nt_flush got=%b exp=0", flush_a); end
    step();
    n_checks++; if (en_a !== 9'h001) begin n_fail++; $display("FAIL jnz_nt_next got=%h exp=001", en_a); end
    idle();
    n_checks++; if (en_a !== 9'h002) begin n_fail++; $display("FAIL jnz_nt_next2 got=%h exp=002", en_a); end
    idle();
    zero_flag = 1'b0;
    fetch(8'hF3);
    fetch(8'h05);
    next_instr = 8'h8A; instr_valid = 1'b1;
    #1;
    n_checks++; if (flush_a !== 1'b1) begin n_fail++; $display("FAIL jnz_t_flush got=%b exp=1", flush_a); end
    step();
    n_checks++; if (en_a !== 9'h000 || flush_a !== 1'b0) begin n_fail++; $display("FAIL jnz_t_squash1 got en=%h flush=%b exp 000 0", en_a, flush_a); end
    idle();
    n_checks++; if (en_a !== 9'h000) begin n_fail++; $display("FAIL jnz_t_squash2 got=%h exp=000", en_a); end
    zero_flag = 1'b1;
  endtask

  task automatic test_src_mode();
    o_reg = 4'h5;
    fetch(8'h83);
    fetch(8'hA4);
    n_checks++; if (src_b !== 4'd5) begin n_fail++; $display("FAIL indirect_src got=%0d exp=5", src_b); end
    n_checks++; if (src_a !== 4'd3) begin n_fail++; $display("FAIL direct_src got=%0d exp=3", src_a); end
    n_checks++; if (en_b !== 9'h001) begin n_fail++; $display("FAIL indirect_en got=%h exp=001", en_b); end
    idle();
    n_checks++; if (src_b !== 4'd4 || src_a !== 4'd4) begin n_fail++; $display("FAIL mov_r_oreg_src got a=%0d b=%0d exp 4 4", src_a, src_b); end
    n_checks++; if (en_b !== 9'h100 || en_a !== 9'h100) begin n_fail++; $display("FAIL mov_r_oreg_en got a=%h b=%h exp 100 100", en_a, en_b); end
    idle();
  endtask

  task automatic test_hold();
    fetch(8'hC8);
    fetch(8'hE7);
    n_checks++; if (en_a !== 9'h000 || nop_a !== 8'd1) begin n_fail++; $display("FAIL nop_retire got en=%h cnt=%0d exp 000 1", en_a, nop_a); end
    fetch(8'h10);
    hold = 1'b1; next_instr = 8'h20; instr_valid = 1'b1;
    #1;
    n_checks++; if (flush_a !== 1'b0 || ready_a !== 1'b0) begin n_fail++; $display("FAIL hold_comb got flush=%b ready=%b exp 0 0", flush_a, ready_a); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (jmp_a !== 1'b1 || imm_a !== 4'h7 || nop_a !== 8'd1 || flush_a !== 1'b0 || ready_a !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_frozen[%0d] got jmp=%b imm=%h cnt=%0d flush=%b ready=%b exp 1 7 1 0 0", i, jmp_a, imm_a, nop_a, flush_a, ready_a);
      end
    end
    hold = 1'b0;
    #1;
    n_checks++; if (flush_a !== 1'b1 || ready_a !== 1'b1) begin n_fail++; $display("FAIL hold_release got flush=%b ready=%b exp 1 1", flush_a, ready_a); end
    step();
    n_checks++; if (jmp_a !== 1'b0 || en_a !== 9'h000) begin n_fail++; $display("FAIL hold_bubble got jmp=%b en=%h exp 0 000", jmp_a, en_a); end
    idle();
    n_checks++; if (en_a !== 9'h000 || nop_a !== 8'd1) begin n_fail++; $display("FAIL hold_squash got en=%h cnt=%0d exp 000 1", en_a, nop_a); end
  endtask

  task automatic test_reset_mid();
    fetch(8'h05);
    fetch(8'h8A);
    n_checks++; if (en_a !== 9'h001) begin n_fail++; $display("FAIL mid_pre got=%h exp=001", en_a); end
    rst_n = 1'b0; next_instr = 8'hC3;
    step();
    n_checks++; if (en_a !== 9'h1FF || nop_a !== 8'd0) begin n_fail++; $display("FAIL mid_rst got en=%h cnt=%0d exp 1FF 0", en_a, nop_a); end
    step();
    rst_n = 1'b1; instr_valid = 1'b0;
    step();
    n_checks++; if (en_a !== 9'h000 || src_a !== 4'd10) begin n_fail++; $display("FAIL mid_discard got en=%h src=%0d exp 000 10", en_a, src_a); end
  endtask

  task automatic test_nop_saturate();
    logic [7:0] nop_tab [4];
    nop_tab = '{8'hC8, 8'hCF, 8'hD8, 8'hDF};
    for (int i = 0; i < 10; i++) fetch(nop_tab[i % 4]);
    idle();
    n_checks++; if (nop_a !== 8'd10) begin n_fail++; $display("FAIL nop_count10 got=%0d exp=10", nop_a); end
    fetch(8'hC9);
    idle();
    n_checks++; if (nop_a !== 8'd10 || en_a !== 9'h010) begin n_fail++; $display("FAIL non_nop_alu got cnt=%0d en=%h exp 10 010", nop_a, en_a); end
    for (int i = 0; i < 290; i++) fetch(nop_tab[i % 4]);
    idle();
    n_checks++; if (nop_a !== 8'd255) begin n_fail++; $display("FAIL nop_saturate got=%0d exp=255", nop_a); end
    n_checks++; if (nop_b !== 8'd255) begin n_fail++; $display("FAIL nop_saturate_b got=%0d exp=255", nop_b); end
  endtask

  initial begin
    rst_n = 1'b0; next_instr = 8'h00; instr_valid = 1'b0; hold = 1'b0;
    zero_flag = 1'b1; o_reg = 4'h5;
    test_reset();
    test_stream();
    test_jump();
    test_jnz();
    test_src_mode();
    test_hold();
    test_reset_mid();
    test_nop_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
